// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR LED demo: button lanes and LED field positions.
// Both lfsr_ctrl and its testbench import this package.
package lfsr_pkg;

  localparam int NUM_BTN     = 5;
  localparam int BTN_STEP    = 0;
  localparam int BTN_RST     = 1;
  localparam int BTN_LOAD    = 2;
  localparam int BTN_RUN     = 3;

  localparam int LED_STATE_W = 14;
  localparam int LED_RUN     = 14;
  localparam int LED_WRAP    = 15;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser per button lane followed by a rising-edge detector.
// o_pulse is a single-cycle pulse per press, however long the button is held.
module btn_sync_edge #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_btn,
  output logic [N-1:0] o_pulse
);

  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;
  logic [N-1:0] r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/lfsr_ctrl.sv
// Fibonacci LFSR controller: button step / soft reset / seed load / run toggle,
// prescaled auto-step in run mode, and a sticky flag when the sequence returns to its start.
module lfsr_ctrl
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int unsigned TAPS  = 'h1D,
  parameter int unsigned SEED  = 1,
  parameter int          DIV   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn,
  input  logic [7:0]  sw,
  output logic [15:0] ledr
);

  localparam int              PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] L_TAPS = WIDTH'(TAPS);
  localparam logic [WIDTH-1:0] L_SEED = WIDTH'(SEED);
  localparam logic [PW-1:0]    L_LAST = PW'(DIV - 1);

  logic [NUM_BTN-1:0] w_pulse;
  logic               w_step;
  logic               w_soft;
  logic               w_load;
  logic               w_toggle;
  logic               w_unused_btn4;
  logic               w_tick;
  logic               w_adv;
  logic               w_fb;
  logic [WIDTH-1:0]   w_next;
  logic [WIDTH-1:0]   w_sw_raw;
  logic [WIDTH-1:0]   w_sw_val;

  logic [WIDTH-1:0]   r_state;
  logic [WIDTH-1:0]   r_ref;
  logic               r_run;
  logic               r_wrap;
  logic [PW-1:0]      r_presc;

  btn_sync_edge #(.N(NUM_BTN)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn),
    .o_pulse (w_pulse)
  );

  assign w_step        = w_pulse[BTN_STEP];
  assign w_soft        = w_pulse[BTN_RST];
  assign w_load        = w_pulse[BTN_LOAD];
  assign w_toggle      = w_pulse[BTN_RUN];
  assign w_unused_btn4 = w_pulse[4];

  assign w_fb   = ^(r_state & L_TAPS);
  assign w_next = {w_fb, r_state[WIDTH-1:1]};

  // sw is 8 bits: zero-extend for wide LFSRs, truncate for narrow ones.
  always_comb begin
    w_sw_raw = '0;
    for (int i = 0; i < WIDTH && i < 8; i++) begin
      w_sw_raw[i] = sw[i];
    end
    w_sw_val = (w_sw_raw == '0) ? L_SEED : w_sw_raw;
  end

  assign w_tick = r_run && (r_presc == L_LAST);
  assign w_adv  = w_step | w_tick;

  // Prescaler idles at 0 outside run mode so the first tick is a full DIV cycles away.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (!r_run || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= 1'b0;
    end else if (w_toggle) begin
      r_run <= ~r_run;
    end
  end

  // Soft reset and load win over any advance; a tick landing with them is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= L_SEED;
      r_ref   <= L_SEED;
      r_wrap  <= 1'b0;
    end else if (w_soft) begin
      r_state <= L_SEED;
      r_ref   <= L_SEED;
      r_wrap  <= 1'b0;
    end else if (w_load) begin
      r_state <= w_sw_val;
      r_ref   <= w_sw_val;
      r_wrap  <= 1'b0;
    end else if (r_state == '0) begin
      r_state <= L_SEED;
    end else if (w_adv) begin
      r_state <= w_next;
      if (w_next == r_ref) begin
        r_wrap <= 1'b1;
      end
    end
  end

  always_comb begin
    ledr                = '0;
    ledr[WIDTH-1:0]     = r_state;
    ledr[LED_RUN]       = r_run;
    ledr[LED_WRAP]      = r_wrap;
  end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Self-checking bench for lfsr_ctrl (WIDTH=8, TAPS=0x1D, SEED=1, DIV=4) against an
// edge-scheduled behavioural model of the button, priority and run-mode rules.
module tb_lfsr_ctrl;
  import lfsr_pkg::*;

  localparam int         DIV     = 4;
  localparam logic [7:0] TAPS_TB = 8'h1D;
  localparam logic [7:0] SEED_TB = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn = 5'd0;
  logic [7:0]  sw  = 8'd0;
  logic [15:0] ledr;

  lfsr_ctrl #(.WIDTH(8), .TAPS('h1D), .SEED(1), .DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .sw   (sw),
    .ledr (ledr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: sequence state, start-of-period reference, run mode and sticky wrap.
  logic [7:0]  m_state;
  logic [7:0]  m_ref;
  logic        m_run;
  logic        m_wrap;
  int unsigned edge_n    = 0;
  int unsigned run_start = 0;
  logic [4:0]  sched [int unsigned];

  function automatic logic [7:0] nxt(input logic [7:0] s);
    int ones;
    ones = $countones(s & TAPS_TB);
    return 8'((s >> 1) + (ones % 2) * 128);
  endfunction

  function automatic logic [15:0] exp_led();
    return {m_wrap, m_run, 6'b000000, m_state};
  endfunction

  // One clock edge: apply the button actions scheduled for this edge plus any run tick.
  task automatic tick();
    logic [4:0] ev;
    logic       adv_tick;
    logic [7:0] v;
    @(posedge clk);
    edge_n++;
    ev = 5'd0;
    if (sched.exists(edge_n)) begin
      ev = sched[edge_n];
      sched.delete(edge_n);
    end
    if (rst) begin
      m_state = SEED_TB;
      m_ref   = SEED_TB;
      m_run   = 1'b0;
      m_wrap  = 1'b0;
      sched.delete();
    end else begin
      adv_tick = m_run && ((edge_n - run_start) % DIV == 0);
      if (ev[BTN_RUN]) begin
        m_run     = !m_run;
        run_start = edge_n;
      end
      if (ev[BTN_RST]) begin
        m_state = SEED_TB;
        m_ref   = SEED_TB;
        m_wrap  = 1'b0;
      end else if (ev[BTN_LOAD]) begin
        v       = (sw == 8'd0) ? SEED_TB : sw;
        m_state = v;
        m_ref   = v;
        m_wrap  = 1'b0;
      end else if (ev[BTN_STEP] || adv_tick) begin
        m_state = nxt(m_state);
        if (m_state == m_ref) m_wrap = 1'b1;
      end
    end
    #1;
  endtask

  // A newly pressed button acts on the third edge after it is driven.
  task automatic set_btn(input logic [4:0] v);
    logic [4:0]  rising;
    int unsigned k;
    rising = v & ~btn;
    k      = edge_n + 3;
    if (rising != 5'd0) sched[k] = sched.exists(k) ? (sched[k] | rising) : rising;
    btn = v;
  endtask

  task automatic press(input logic [4:0] mask);
    set_btn(mask);
    tick();
    set_btn(5'd0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ledr !== 16'h0001) $display("FAIL reset_state: ledr=%h expected=%h", ledr, 16'h0001);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (ledr !== exp_led()) $display("FAIL reset_idle: ledr=%h expected=%h", ledr, exp_led());
    else n_pass++;
  endtask

  task automatic test_step();
    logic [7:0] seq [5];
    seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    for (int i = 0; i < 5; i++) begin
      set_btn(5'b00001);
      tick();
      n_checks++;
      if (ledr !== exp_led()) $display("FAIL step_edge1: ledr=%h expected=%h", ledr, exp_led());
      else n_pass++;
      set_btn(5'd0);
      tick();
      n_checks++;
      if (ledr !== exp_led()) $display("FAIL step_edge2: ledr=%h expected=%h", ledr, exp_led());
      else n_pass++;
      tick();
      n_checks++;
      if (ledr !== {8'h00, seq[i]}) $display("FAIL step_edge3: ledr=%h expected=%h", ledr, {8'h00, seq[i]});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_hold_priority();
    set_btn(5'b00001);
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if (ledr !== exp_led()) $display("FAIL hold_cycle: ledr=%h expected=%h", ledr, exp_led());
      else n_pass++;
    end
    set_btn(5'd0);
    repeat (4) tick();
    n_checks++;
    if (ledr !== 16'h00C4) $display("FAIL hold_one_advance: ledr=%h expected=%h", ledr, 16'h00C4);
    else n_pass++;
    press(5'b00011);
    n_checks++;
    if (ledr !== 16'h0001) $display("FAIL priority_soft_over_step: ledr=%h expected=%h", ledr, 16'h0001);
    else n_pass++;
    tick();
  endtask

  task automatic test_load();
    sw = 8'hA5;
    press(5'b00100);
    n_checks++;
    if (ledr !== 16'h00A5) $display("FAIL load_a5: ledr=%h expected=%h", ledr, 16'h00A5);
    else n_pass++;
    tick();
    sw = 8'h00;
    press(5'b00100);
    n_checks++;
    if (ledr !== 16'h0001) $display("FAIL load_zero_subst: ledr=%h expected=%h", ledr, 16'h0001);
    else n_pass++;
    tick();
    for (int i = 0; i < 6; i++) begin
      sw = 8'($urandom_range(0, 255));
      press(5'b00100);
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) begin
        press(5'b00001);
        n_checks++;
        if (ledr !== exp_led()) $display("FAIL load_rand_walk: ledr=%h expected=%h", ledr, exp_led());
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    press(5'b00010);
    n_checks++;
    if (ledr !== 16'h0001) $display("FAIL wrap_soft_start: ledr=%h expected=%h", ledr, 16'h0001);
    else n_pass++;
    for (int i = 1; i <= 254; i++) begin
      press(5'b00001);
      tick();
      n_checks++;
      if (ledr[15] !== 1'b0 || ledr !== exp_led())
        $display("FAIL wrap_walk: step=%0d ledr=%h expected=%h", i, ledr, exp_led());
      else n_pass++;
    end
    press(5'b00001);
    n_checks++;
    if (ledr !== 16'h8001) $display("FAIL wrap_set: ledr=%h expected=%h", ledr, 16'h8001);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      press(5'b00001);
      n_checks++;
      if (ledr[15] !== 1'b1 || ledr !== exp_led())
        $display("FAIL wrap_sticky: ledr=%h expected=%h", ledr, exp_led());
      else n_pass++;
    end
    sw = 8'($urandom_range(1, 255));
    press(5'b00100);
    n_checks++;
    if (ledr !== {8'h00, sw}) $display("FAIL wrap_clear_on_load: ledr=%h expected=%h", ledr, {8'h00, sw});
    else n_pass++;
    tick();
  endtask

  task automatic test_run();
    logic [7:0] s0;
    logic [4:0] mask;
    int         act;
    press(5'b01000);
    n_checks++;
    if (ledr[LED_RUN] !== 1'b1 || ledr !== exp_led()) $display("FAIL run_on: ledr=%h expected=%h", ledr, exp_led());
    else n_pass++;
    s0 = ledr[7:0];
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ledr[7:0] !== s0) $display("FAIL run_no_early: ledr=%h expected=%h", ledr[7:0], s0);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (ledr[7:0] !== nxt(s0)) $display("FAIL run_first_tick: ledr=%h expected=%h", ledr[7:0], nxt(s0));
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (ledr !== exp_led()) $display("FAIL run_period: ledr=%h expected=%h", ledr, exp_led());
      else n_pass++;
    end
    // Arrange for a step pulse to land on the same edge as a run tick.
    tick();
    set_btn(5'b00001);
    tick();
    set_btn(5'd0);
    tick();
    s0 = ledr[7:0];
    tick();
    n_checks++;
    if (ledr[7:0] !== nxt(s0) || ledr !== exp_led())
      $display("FAIL run_coincident_step: ledr=%h expected=%h", ledr, {8'h40, nxt(s0)});
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      act  = int'($urandom_range(0, 3));
      mask = (act == 1) ? 5'b00001 : (act == 2) ? 5'b00100 : (act == 3) ? 5'b10000 : 5'b00000;
      if (act == 2) sw = 8'($urandom_range(0, 255));
      set_btn(mask);
      tick();
      set_btn(5'd0);
      for (int j = 0; j < int'($urandom_range(2, 7)); j++) begin
        tick();
        n_checks++;
        if (ledr !== exp_led()) $display("FAIL run_random: ledr=%h expected=%h", ledr, exp_led());
        else n_pass++;
      end
    end
    press(5'b01000);
    n_checks++;
    if (ledr[LED_RUN] !== 1'b0 || ledr !== exp_led()) $display("FAIL run_off: ledr=%h expected=%h", ledr, exp_led());
    else n_pass++;
    s0 = ledr[7:0];
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (ledr[7:0] !== s0) $display("FAIL run_frozen: ledr=%h expected=%h", ledr[7:0], s0);
      else n_pass++;
    end
    press(5'b01000);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (ledr !== 16'h0001) $display("FAIL rst_mid_run: ledr=%h expected=%h", ledr, 16'h0001);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (ledr !== exp_led()) $display("FAIL after_rst_idle: ledr=%h expected=%h", ledr, exp_led());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_hold_priority();
    test_load();
    test_wrap();
    test_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
